ir_sense_seq: RTL and testbench
===============================

Name: ir_sense_seq

Overview:
- Periodic sequencer that owns the IR emitter enable and the shared 8-channel A2D converter.
- Each period it fires the emitters, waits for them to settle, then converts all eight IR receivers (R0..R3, L0..L3) one at a time.
- It latches the eight 12-bit results and issues a single-cycle IR_vld strobe.
- Sits directly upstream of the error-compute block, which consumes IR_R0..IR_L3 on IR_vld.

Parameters:
PERIOD_W, 17, width of the free-running period timer; one reading cycle is started every 2^PERIOD_W clocks.
SETTLE_CYC, 1024, clocks IR_en is high before the first conversion starts (1 to 65535).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cnv_cmplt  input  1  A2D conversion-complete pulse (1 clk)
res  input  12  A2D result; valid in the cycle cnv_cmplt=1
strt_cnv  output  1  one-clock request to start an A2D conversion
chnnl  output  3  A2D channel for the current/next conversion
IR_en  output  1  IR emitter enable
IR_R0, IR_R1, IR_R2, IR_R3  output  12 each  latched right-receiver readings
IR_L0, IR_L1, IR_L2, IR_L3  output  12 each  latched left-receiver readings
IR_vld  output  1  one-clock strobe: all eight readings are updated

Behaviour:
- Reset: all outputs are 0, state is IDLE, period timer is 0, index is 0, settle counter is 0. Reset is honoured mid-conversion; there is no resume after reset.
- Period timer is a free-running PERIOD_W-bit up-counter. The tick condition is timer == all ones. The counter wraps to 0 after a tick.
- State machine (registered state; outputs are registered or decoded from registered state, with no input-to-output combinational path):
  - IDLE: on tick, set IR_en=1, clear the settle counter, and go to SETTLE.
  - SETTLE: increment the settle counter. When it equals SETTLE_CYC-1, go to CONV.
  - CONV: drive strt_cnv=1 for exactly this one cycle, with chnnl=idx. Go to WAIT.
  - WAIT: hold chnnl. On cnv_cmplt, store res into slot idx.
    - If idx==7, go to DONE.
    - Otherwise idx++ and go to CONV.
  - DONE: IR_vld=1 for one cycle, IR_en=0 at the next edge, idx=0, go to IDLE.
- Slot and channel map (idx = chnnl):
  - Even idx goes to IR_R(idx/2): 0 to R0, 2 to R1, 4 to R2, 6 to R3.
  - Odd idx goes to IR_L(idx/2): 1 to L0, 3 to L1, 5 to L2, 7 to L3.
  - Result registers hold their value until overwritten. They are updated progressively during the sequence, so consumers sample them only on IR_vld.
- Timing from a tick seen at edge T (no A2D latency, i.e. cnv_cmplt is answered in the first WAIT cycle):
  - IR_en rises at T+1.
  - First strt_cnv is high in the cycle after edge T+1+SETTLE_CYC.
  - Each conversion costs 2 clocks plus the A2D latency.
- Boundary conditions:
  - A tick while not in IDLE is ignored; that period is skipped.
  - A tick in the same cycle as the DONE→IDLE transition is also ignored.
  - cnv_cmplt outside WAIT is ignored, and res is not sampled.
  - cnv_cmplt in the same cycle as strt_cnv (the CONV state) is ignored.
  - There is no timeout. A missing cnv_cmplt holds WAIT indefinitely, with IR_en high.
  - IR_en is high continuously from SETTLE entry through the DONE cycle.
  - The timer keeps counting in all states.

Decomposition:
- Package ir_seq_pkg:
  - enum state_t {IDLE, SETTLE, CONV, WAIT, DONE}
  - localparam NUM_CH=8
  - localparam LAST_IDX=3'd7
- Sub-module ir_period_timer (PERIOD_W): free-running counter with a tick output.
- FSM, settle counter, index and result registers stay in ir_sense_seq.

Test Plan (PERIOD_W=8, SETTLE_CYC=4, A2D model answers 3 clocks after strt_cnv with res=12'h100+chnnl):
- Release reset and run one period → first tick at cycle 255 after reset; IR_en rises at 256; first strt_cnv is 4 cycles later with chnnl=0.
- Full sequence → eight strt_cnv pulses with chnnl 0..7 in order; IR_vld one cycle; IR_R0=100, IR_L0=101, IR_R1=102 … IR_L3=107 (hex); IR_en low the cycle after IR_vld.
- Spurious cnv_cmplt with res=FFF during SETTLE and in the CONV cycle → ignored; all results match the previous scenario.
- Stall the A2D (no cnv_cmplt for 600 clocks on channel 3) → the FSM stays in WAIT, IR_en stays 1, the next tick is ignored; releasing the stall completes the sequence normally.
- Assert rst_n low while waiting on channel 5 → all outputs 0 immediately; after release, the next sequence restarts at chnnl=0 after a full period.
- Two back-to-back periods with different res values → the second IR_vld shows the new values, and the result registers are stable between strobes.

Source files
------------

// File: rtl/ir_seq_pkg.sv
// Shared types and constants for the IR sense sequencer.
package ir_seq_pkg;

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned RES_W    = 12;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned SETTLE_W = 16;

    localparam logic [CH_W-1:0] LAST_IDX = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONV,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/ir_period_timer.sv
// Free-running period counter; tick_c is high for the one cycle the count is all ones.
module ir_period_timer #(
    parameter int unsigned PERIOD_W = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c
);

    logic [PERIOD_W-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer <= '0;
        else        timer <= timer + PERIOD_W'(1);
    end

    assign tick_c = &timer;

endmodule

// File: rtl/ir_sense_seq.sv
// Periodic IR emitter / A2D sequencer: settle, convert eight receivers, strobe IR_vld.
module ir_sense_seq
    import ir_seq_pkg::*;
#(
    parameter int unsigned PERIOD_W   = 17,
    parameter int unsigned SETTLE_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    output logic             strt_cnv,
    output logic [CH_W-1:0]  chnnl,
    output logic             IR_en,
    output logic [RES_W-1:0] IR_R0,
    output logic [RES_W-1:0] IR_R1,
    output logic [RES_W-1:0] IR_R2,
    output logic [RES_W-1:0] IR_R3,
    output logic [RES_W-1:0] IR_L0,
    output logic [RES_W-1:0] IR_L1,
    output logic [RES_W-1:0] IR_L2,
    output logic [RES_W-1:0] IR_L3,
    output logic             IR_vld
);

    logic                tick_c;
    state_t              state;
    state_t              nxt_state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [CH_W-1:0]     idx;
    logic [RES_W-1:0]    res_q [NUM_CH];
    logic                settle_done_c;
    logic                store_c;

    ir_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_c (tick_c)
    );

    assign settle_done_c = (settle_cnt == SETTLE_W'(SETTLE_CYC - 1));
    assign store_c       = (state == WAIT) && cnv_cmplt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (tick_c) nxt_state = SETTLE;
            SETTLE:  if (settle_done_c) nxt_state = CONV;
            CONV:    nxt_state = WAIT;
            WAIT:    if (cnv_cmplt) nxt_state = (idx == LAST_IDX) ? DONE : CONV;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strt_cnv <= 1'b0;
            IR_vld   <= 1'b0;
            IR_en    <= 1'b0;
        end else begin
            strt_cnv <= (nxt_state == CONV);
            IR_vld   <= (nxt_state == DONE);
            IR_en    <= (nxt_state != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) settle_cnt <= '0;
        else if (state == SETTLE) settle_cnt <= settle_cnt + SETTLE_W'(1);
        else settle_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx <= '0;
        else if (store_c && (idx != LAST_IDX)) idx <= idx + CH_W'(1);
        else if (state == DONE) idx <= '0;
    end

    // Slot idx holds channel idx; results persist until the next sequence overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) res_q[i] <= '0;
        end else if (store_c) begin
            res_q[idx] <= res;
        end
    end

    assign chnnl = idx;
    assign IR_R0 = res_q[0];
    assign IR_L0 = res_q[1];
    assign IR_R1 = res_q[2];
    assign IR_L1 = res_q[3];
    assign IR_R2 = res_q[4];
    assign IR_L2 = res_q[5];
    assign IR_R3 = res_q[6];
    assign IR_L3 = res_q[7];

endmodule

// File: tb/tb_ir_sense_seq.sv
// Bench for ir_sense_seq: event-timeline model plus directed scenarios with literal expectations.
module tb_ir_sense_seq;

    localparam int PERIOD_W = 8;
    localparam int PERIOD   = 1 << PERIOD_W;
    localparam int SETTLE   = 4;

    logic        clk;
    logic        rst_n;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        IR_en;
    logic        IR_vld;
    logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3;

    int checks = 0;
    int errors = 0;

    // A2D model controls
    logic [11:0] res_base  = 12'h100;
    bit          stall     = 1'b0;
    bit          dbl       = 1'b0;
    bit          spur_once = 1'b0;

    ir_sense_seq #(.PERIOD_W(PERIOD_W), .SETTLE_CYC(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .IR_en     (IR_en),
        .IR_R0     (IR_R0),
        .IR_R1     (IR_R1),
        .IR_R2     (IR_R2),
        .IR_R3     (IR_R3),
        .IR_L0     (IR_L0),
        .IR_L1     (IR_L1),
        .IR_L2     (IR_L2),
        .IR_L3     (IR_L3),
        .IR_vld    (IR_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A2D: answers 3 clocks after strt_cnv with res_base+channel; optional stall and spurious pulses.
    initial begin : a2d
        bit         s;
        logic [2:0] c;
        logic [2:0] a_ch;
        int         cd;
        bit         dbl_pend;
        cnv_cmplt = 1'b0;
        res       = 12'hEEE;
        cd        = 0;
        a_ch      = 3'd0;
        dbl_pend  = 1'b0;
        forever begin
            @(negedge clk);
            s = strt_cnv;
            c = chnnl;
            @(posedge clk);
            #1;
            cnv_cmplt = 1'b0;
            res       = 12'hEEE;
            if (dbl_pend || spur_once) begin
                cnv_cmplt = 1'b1;
                res       = 12'hFFF;
                dbl_pend  = 1'b0;
                spur_once = 1'b0;
            end
            if (!rst_n) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        if (stall && a_ch == 3'd3) begin
                            cd = 1;
                        end else begin
                            cnv_cmplt = 1'b1;
                            res       = res_base + 12'(a_ch);
                            if (dbl) dbl_pend = 1'b1;
                        end
                    end
                end
                if (s) begin
                    cd   = 2;
                    a_ch = c;
                end
            end
        end
    end

    // Timeline model: tracks when the next strobe/start is due and what each slot must hold.
    int          mcyc;
    bit          m_busy;
    bit          m_await;
    int          m_ch;
    int          m_strt_at;
    int          m_vld_at;
    logic [11:0] m_res [8];

    always @(negedge clk) begin : compare
        logic [11:0] dres [8];
        dres[0] = IR_R0; dres[1] = IR_L0; dres[2] = IR_R1; dres[3] = IR_L1;
        dres[4] = IR_R2; dres[5] = IR_L2; dres[6] = IR_R3; dres[7] = IR_L3;
        if (!rst_n) begin
            chk("rst_IR_en", 32'(IR_en), 0);
            chk("rst_strt_cnv", 32'(strt_cnv), 0);
            chk("rst_IR_vld", 32'(IR_vld), 0);
            chk("rst_chnnl", 32'(chnnl), 0);
            for (int k = 0; k < 8; k++) chk($sformatf("rst_slot%0d", k), 32'(dres[k]), 0);
            mcyc = 0; m_busy = 0; m_await = 0; m_ch = 0; m_strt_at = -1; m_vld_at = -1;
            for (int k = 0; k < 8; k++) m_res[k] = 12'h000;
        end else begin
            chk("IR_en", 32'(IR_en), 32'(m_busy));
            chk("strt_cnv", 32'(strt_cnv), 32'(m_strt_at == mcyc));
            chk("chnnl", 32'(chnnl), 32'(m_ch));
            chk("IR_vld", 32'(IR_vld), 32'(m_vld_at == mcyc));
            for (int k = 0; k < 8; k++) chk($sformatf("slot%0d", k), 32'(dres[k]), 32'(m_res[k]));
            if (m_vld_at == mcyc) begin
                m_busy = 0; m_ch = 0; m_vld_at = -1;
            end else if (!m_busy && (mcyc % PERIOD) == PERIOD - 1) begin
                m_busy = 1; m_ch = 0; m_strt_at = mcyc + 1 + SETTLE;
            end else if (m_busy) begin
                if (m_await && cnv_cmplt) begin
                    m_res[m_ch] = res;
                    m_await     = 0;
                    if (m_ch == 7) m_vld_at = mcyc + 1;
                    else begin
                        m_ch++;
                        m_strt_at = mcyc + 1;
                    end
                end else if (m_strt_at == mcyc) begin
                    m_await = 1;
                end
            end
            mcyc++;
        end
    end

    // kind 0: IR_en high, 1: strt_cnv on channel ch, 2: IR_vld. n = negedges waited before the hit.
    task automatic wait_ev(input int kind, input int ch, input int bound, output int n);
        bit hit;
        n   = -1;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            if ((kind == 0 && IR_en) || (kind == 1 && strt_cnv && chnnl == 3'(ch)) ||
                (kind == 2 && IR_vld)) begin
                n   = i;
                hit = 1'b1;
            end
        end
        if (!hit) chk($sformatf("timeout_kind%0d_ch%0d", kind, ch), 0, 1);
    endtask

    task automatic chk_all(input string tag, input logic [11:0] base);
        chk({tag, "_R0"}, 32'(IR_R0), 32'(base + 12'h0));
        chk({tag, "_L0"}, 32'(IR_L0), 32'(base + 12'h1));
        chk({tag, "_R1"}, 32'(IR_R1), 32'(base + 12'h2));
        chk({tag, "_L1"}, 32'(IR_L1), 32'(base + 12'h3));
        chk({tag, "_R2"}, 32'(IR_R2), 32'(base + 12'h4));
        chk({tag, "_L2"}, 32'(IR_L2), 32'(base + 12'h5));
        chk({tag, "_R3"}, 32'(IR_R3), 32'(base + 12'h6));
        chk({tag, "_L3"}, 32'(IR_L3), 32'(base + 12'h7));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First period: tick at cycle 255, IR_en in 256, strt_cnv in 260 on channel 0.
        wait_ev(0, 0, 400, n);
        chk("first_en_cycle", 32'(n), 256);
        wait_ev(1, 0, 20, n);
        chk("first_strt_delay", 32'(n), 3);
        wait_ev(2, 0, 200, n);
        chk("seq1_R0_lit", 32'(IR_R0), 32'h100);
        chk("seq1_L0_lit", 32'(IR_L0), 32'h101);
        chk("seq1_R1_lit", 32'(IR_R1), 32'h102);
        chk("seq1_L3_lit", 32'(IR_L3), 32'h107);
        chk_all("seq1", 12'h100);
        @(negedge clk);
        chk("en_after_vld", 32'(IR_en), 0);
        chk("vld_one_cycle", 32'(IR_vld), 0);

        // Spurious completions during SETTLE and in each CONV cycle.
        dbl = 1'b1;
        wait_ev(0, 0, 400, n);
        spur_once = 1'b1;
        wait_ev(2, 0, 200, n);
        dbl = 1'b0;
        chk_all("spur", 12'h100);

        // Stall channel 3 across a tick.
        stall = 1'b1;
        wait_ev(1, 3, 600, n);
        repeat (600) @(negedge clk);
        chk("stall_en", 32'(IR_en), 1);
        chk("stall_chnnl", 32'(chnnl), 3);
        chk("stall_vld", 32'(IR_vld), 0);
        stall = 1'b0;
        wait_ev(2, 0, 100, n);
        chk_all("stall", 12'h100);

        // Reset while waiting on channel 5.
        wait_ev(1, 5, 600, n);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_IR_en", 32'(IR_en), 0);
        chk("arst_chnnl", 32'(chnnl), 0);
        chk("arst_R0", 32'(IR_R0), 0);
        chk("arst_L1", 32'(IR_L1), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ev(0, 0, 400, n);
        chk("rst_en_cycle", 32'(n), 256);
        wait_ev(1, 0, 20, n);
        chk("rst_strt_delay", 32'(n), 3);

        // Back-to-back periods with new results.
        wait_ev(2, 0, 200, n);
        chk_all("bb1", 12'h100);
        repeat (50) @(negedge clk);
        chk("hold_R0", 32'(IR_R0), 32'h100);
        chk("hold_L3", 32'(IR_L3), 32'h107);
        res_base = 12'h200;
        wait_ev(2, 0, 400, n);
        chk("bb2_R0_lit", 32'(IR_R0), 32'h200);
        chk("bb2_L3_lit", 32'(IR_L3), 32'h207);
        chk_all("bb2", 12'h200);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
